// File: rtl/image2three.sv
// Line buffer feeding the 3-row window expander: stores padded feature-map rows
// in a 4-bank ring and serves the three oldest held rows as one wide word.
module image2three #(
  parameter int unsigned WIDTH_DATA         = 8,
  parameter int unsigned PICTURE_NUM        = 1,
  parameter int unsigned CHANNEL_IN_NUM     = 16,
  parameter int unsigned WIDTH_RAM_SIZE     = 12,
  parameter int unsigned WIDTH_FEATURE_SIZE = 12,
  parameter int unsigned WIDTH_CHANNEL_NUM  = 10
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   Start,
  input  logic [WIDTH_FEATURE_SIZE-1:0]                          Row_Num_After_Padding,
  input  logic [WIDTH_CHANNEL_NUM-1:0]                           Channel_In_Num_REG,
  input  logic [WIDTH_DATA*PICTURE_NUM*CHANNEL_IN_NUM-1:0]       S_Data,
  input  logic                                                   S_Valid,
  output logic                                                   S_Ready,
  input  logic [WIDTH_RAM_SIZE-1:0]                              Rd_Addr,
  output logic [3*WIDTH_DATA*PICTURE_NUM*CHANNEL_IN_NUM-1:0]     M_Feature,
  output logic                                                   Row_Compute_Sign,
  input  logic                                                   Row_Done,
  output logic                                                   Done
);

  localparam int unsigned W        = WIDTH_DATA * PICTURE_NUM * CHANNEL_IN_NUM;
  localparam int unsigned DEPTH    = 1 << WIDTH_RAM_SIZE;
  localparam int unsigned LW       = WIDTH_RAM_SIZE + 1;
  localparam int unsigned FW       = WIDTH_FEATURE_SIZE;
  localparam int unsigned PW       = WIDTH_FEATURE_SIZE + WIDTH_CHANNEL_NUM;
  localparam int unsigned CH_SHIFT = $clog2(CHANNEL_IN_NUM);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [FW-1:0]             r_q, r_d;
  logic [LW-1:0]             l_q, l_d;
  logic [1:0]                wr_bank_q, wr_bank_d;
  logic [WIDTH_RAM_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [FW-1:0]             rows_written_q, rows_written_d;
  logic [2:0]                held_q, held_d;
  logic [1:0]                rd_bank_q, rd_bank_d;
  logic [FW-1:0]             windows_q, windows_d;
  logic                      s_ready_q, s_ready_d;
  logic                      sign_q, sign_d;
  logic                      done_q, done_d;
  logic [3*W-1:0]            m_feature_q;

  logic [W-1:0]              bank_mem [4][DEPTH];

  logic [WIDTH_CHANNEL_NUM-1:0] groups_c;
  logic [PW-1:0]                row_len_c;
  logic                         beat_c;
  logic                         row_end_c;
  logic                         free_c;
  logic [1:0]                   rd_bank1_c;
  logic [1:0]                   rd_bank2_c;

  assign groups_c   = Channel_In_Num_REG >> CH_SHIFT;
  assign row_len_c  = PW'(Row_Num_After_Padding) * PW'(groups_c);
  assign beat_c     = S_Valid && s_ready_q;
  assign row_end_c  = beat_c && ({1'b0, wr_addr_q} == (l_q - LW'(1)));
  assign free_c     = (state_q == RUN) && Row_Done && (held_q >= 3'd3);
  assign rd_bank1_c = rd_bank_q + 2'd1;
  assign rd_bank2_c = rd_bank_q + 2'd2;

  // State, pointer and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      r_q            <= '0;
      l_q            <= '0;
      wr_bank_q      <= '0;
      wr_addr_q      <= '0;
      rows_written_q <= '0;
      held_q         <= '0;
      rd_bank_q      <= '0;
      windows_q      <= '0;
      s_ready_q      <= 1'b0;
      sign_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      r_q            <= r_d;
      l_q            <= l_d;
      wr_bank_q      <= wr_bank_d;
      wr_addr_q      <= wr_addr_d;
      rows_written_q <= rows_written_d;
      held_q         <= held_d;
      rd_bank_q      <= rd_bank_d;
      windows_q      <= windows_d;
      s_ready_q      <= s_ready_d;
      sign_q         <= sign_d;
      done_q         <= done_d;
    end
  end

  // Next-state, ring bookkeeping and registered-output decode
  always_comb begin
    state_d        = state_q;
    r_d            = r_q;
    l_d            = l_q;
    wr_bank_d      = wr_bank_q;
    wr_addr_d      = wr_addr_q;
    rows_written_d = rows_written_q;
    held_d         = held_q;
    rd_bank_d      = rd_bank_q;
    windows_d      = windows_q;
    s_ready_d      = 1'b0;
    sign_d         = 1'b0;
    done_d         = 1'b0;

    if (beat_c) begin
      wr_addr_d = row_end_c ? '0 : wr_addr_q + WIDTH_RAM_SIZE'(1);
    end
    if (row_end_c) begin
      wr_bank_d      = wr_bank_q + 2'd1;
      rows_written_d = rows_written_q + FW'(1);
    end
    if (free_c) begin
      rd_bank_d = rd_bank_q + 2'd1;
      windows_d = windows_q + FW'(1);
    end
    // Completion and free on the same edge leave the held count unchanged
    case ({row_end_c, free_c})
      2'b10:   held_d = held_q + 3'd1;
      2'b01:   held_d = held_q - 3'd1;
      default: held_d = held_q;
    endcase

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d        = RUN;
          r_d            = Row_Num_After_Padding;
          l_d            = LW'(row_len_c);
          wr_bank_d      = '0;
          wr_addr_d      = '0;
          rows_written_d = '0;
          held_d         = '0;
          rd_bank_d      = '0;
          windows_d      = '0;
        end
      end
      RUN: begin
        if (windows_q == (r_q - FW'(2))) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    s_ready_d = (state_d == RUN) && (rows_written_d < r_d) && (held_d < 3'd4);
    sign_d    = !Row_Done && (state_q == RUN) && (held_q >= 3'd3) &&
                (windows_q < (r_q - FW'(2)));
    done_d    = (state_d == FINISH);
  end

  // Row bank write port; the bank being written is never one of the three read
  always_ff @(posedge clk) begin
    if (beat_c) begin
      bank_mem[wr_bank_q][wr_addr_q] <= S_Data;
    end
  end

  // Three-row read with one cycle of latency, oldest row in the low slice
  always_ff @(posedge clk) begin
    if (rst) begin
      m_feature_q <= '0;
    end else begin
      m_feature_q <= {bank_mem[rd_bank2_c][Rd_Addr],
                      bank_mem[rd_bank1_c][Rd_Addr],
                      bank_mem[rd_bank_q][Rd_Addr]};
    end
  end

  assign S_Ready          = s_ready_q;
  assign Row_Compute_Sign = sign_q;
  assign Done             = done_q;
  assign M_Feature        = m_feature_q;

endmodule

// File: doc/image2three.md
Name: image2three

Overview:
- Line-buffer stage directly upstream of the 3-row to 9-lane window expander.
- Accepts a padded feature map as a stream of channel-group words and stores rows in a 4-bank ring of row RAMs.
- Raises Row_Compute_Sign when three consecutive complete rows are held. Serves them as one 3-row word at a downstream-driven read address.
- Frees the oldest row on each Row_Done, so windows slide by one row.

Parameters:
- CHANNEL_IN_NUM, 16, channels per word; must be a power of 2. Word width W = `WIDTH_DATA*`PICTURE_NUM*CHANNEL_IN_NUM.
- WIDTH_RAM_SIZE, 12, address width of each row bank; bank depth 2^WIDTH_RAM_SIZE words.
- WIDTH_FEATURE_SIZE, 12, width of row/column counts.
- WIDTH_CHANNEL_NUM, 10, width of the channel count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- Start  in  1  frame start pulse; honoured only in IDLE
- Row_Num_After_Padding  in  WIDTH_FEATURE_SIZE  padded width = height R; R >= 3
- Channel_In_Num_REG  in  WIDTH_CHANNEL_NUM  input channels; multiple of CHANNEL_IN_NUM
- S_Data  in  W  input word
- S_Valid  in  1  input word valid
- S_Ready  out  1  input can be accepted
- Rd_Addr  in  WIDTH_RAM_SIZE  read address, driven by downstream
- M_Feature  out  3W  three-row output word
- Row_Compute_Sign  out  1  three rows available for a window row
- Row_Done  in  1  one-cycle pulse: downstream finished the current window row
- Done  out  1  one-cycle pulse: frame complete

Behaviour:
- Reset values: S_Ready=0, Row_Compute_Sign=0, M_Feature=0, Done=0. All pointers and counters are 0 and the state is IDLE.
- A reset mid-frame aborts the frame immediately. Bank contents are don't-care.
- Start is a pulse; params are sampled on it. G = Channel_In_Num_REG >> log2(CHANNEL_IN_NUM). L = R*G words per row. L <= 2^WIDTH_RAM_SIZE is required.
- States: IDLE, RUN, FINISH.
  - IDLE -> RUN on Start. Latch R and L; clear wr_bank, wr_addr, rows_written, held, rd_bank, windows.
  - RUN -> FINISH when windows == R-2 (last Row_Done taken).
  - FINISH -> IDLE after one cycle; Done=1 for that one cycle.
- Start outside IDLE is ignored.
- Write path:
  - Beat = S_Valid && S_Ready. It writes S_Data to bank wr_bank at wr_addr.
  - wr_addr increments and wraps to 0 at L-1.
  - On wrap: wr_bank = (wr_bank+1) mod 4, rows_written+1, held+1.
- S_Ready (registered) is 1 only in RUN, with rows_written < R and held < 4 after the current update. S_Ready deasserts on the cycle after the row completion that makes held == 4.
- Free path: Row_Done with held >= 3 does rd_bank = (rd_bank+1) mod 4, held-1, windows+1. Row_Done with held < 3 is ignored.
- Simultaneous row completion and Row_Done: held is unchanged and both pointers advance.
- Row_Compute_Sign is registered:
  - Cleared to 0 in any cycle where Row_Done=1.
  - Otherwise set to (state==RUN && held >= 3 && windows < R-2).
  - It rises one cycle after the edge at which held reaches 3. It is low for at least one cycle after each Row_Done.
- Read path, 1-cycle latency: M_Feature is registered from Rd_Addr sampled at edge N and valid after edge N+1.
  - M_Feature[W-1:0] = bank rd_bank (oldest/top row).
  - M_Feature[2W-1:W] = bank rd_bank+1.
  - M_Feature[3W-1:2W] = bank rd_bank+2. Bank indices are mod 4.
- Writes to the 4th bank may overlap reads of the other three. The bank being read is never written: held < 4 guarantees this.
- Total words accepted per frame = R*L. Total Row_Compute_Sign windows = R-2.

Test Plan:
- R=6, Channel_In_Num_REG=16 (L=6), S_Valid always high, Row_Done issued 20 cycles after each Sign rise -> 36 words accepted; Sign rises 1 cycle after the 18th beat edge; exactly 4 Sign windows; Done pulses once; back to IDLE.
- Same config, Row_Done withheld -> S_Ready falls after the 24th beat; no further beats accepted; the first Row_Done restores S_Ready the next cycle.
- R=5, Channel_In_Num_REG=32 (L=10): rows filled with value row*100+addr; after Sign, sweep Rd_Addr 0..9 -> M_Feature slices equal rows 0,1,2 one cycle after each address; after Row_Done, rows 1,2,3.
- Row completion and Row_Done on the same edge -> held unchanged; rd_bank and wr_bank both advance; data mapping stays correct.
- rst asserted mid-frame after 10 beats -> next cycle all outputs 0, IDLE; a new Start runs a full frame correctly.
- Row_Done pulsed while Sign is low with held=2, and Start pulsed during RUN -> both ignored; counters and frame progress are unaffected.
